// File: rtl/sc_mul_scheduler.sv
// sc_mul_scheduler
// Round-robin front end that time-shares one sc_serial_mul among NUM_REQ
// requesters. Each operation latches one operand set, pulses the multiplier
// clear, enables it until done (or a timeout), then returns the result
// tagged with the requester id over a valid/ready response port.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   req_valid    per-requester request
//   req_data     operand sets, requester r operand i at (r*NUM_INPUTS+i)*DATA_WIDTH
//   req_ready    one-hot grant (transfer on req_valid & req_ready)
//   mul_clr      one-cycle clear pulse to the multiplier
//   mul_en       multiplier enable
//   mul_data_in  latched operands for the multiplier
//   mul_data_out multiplier result
//   mul_done     multiplier completion
//   resp_valid   response available
//   resp_ready   consumer accept
//   resp_id      requester that owns the response
//   resp_data    result (0 on timeout)
//   resp_err     1 = operation aborted by timeout
//   busy         high whenever the scheduler is not idle
module sc_mul_scheduler #(
    parameter int DATA_WIDTH     = 4,
    parameter int NUM_INPUTS     = 2,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             mul_clr,
    output logic                             mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data_out,
    input  logic                             mul_done,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [ID_W-1:0]                  resp_id,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] resp_data,
    output logic                             resp_err,
    output logic                             busy
);

    localparam int OPW   = NUM_INPUTS * DATA_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

    state_t             state, state_nx;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;

    // Round-robin pick: first asserted request at or above the pointer,
    // wrapping around. The found flag stops later hits from overriding.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    // The grant is only offered while idle; gating with rst keeps it at
    // zero while reset is held even though requests may be pending.
    assign req_ready  = (state == IDLE && rst) ? grant : '0;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign resp_id    = cur_id;

    // Next-state and multiplier strobes. Done has priority over timeout
    // because it is tested first in RUN.
    always_comb begin
        state_nx = state;
        mul_clr  = 1'b0;
        mul_en   = 1'b0;
        case (state)
            IDLE:  if (grant_any) state_nx = CLEAR;
            CLEAR: begin
                mul_clr  = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                mul_en = 1'b1;
                if (mul_done || cnt == LAST_CNT) state_nx = RESP;
            end
            RESP:  if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, pointer, operand latch, run counter and response registers.
    // Operands stay latched until the next grant so the multiplier sees a
    // stable input across the whole operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cur_id      <= '0;
            cnt         <= '0;
            mul_data_in <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mul_data_in <= req_data[grant_id*OPW +: OPW];
                        cur_id      <= grant_id;
                        ptr         <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                CLEAR: cnt <= '0;
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        resp_data <= mul_data_out;
                        resp_err  <= 1'b0;
                    end else if (cnt == LAST_CNT) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sc_mul_scheduler.md
Name: sc_mul_scheduler

Overview:
- Round-robin scheduler that shares one sc_serial_mul instance among NUM_REQ requesters.
- Per operation: accepts one operand set, clears the multiplier, enables it, and waits for done (or a timeout).
- Returns the tagged result over a valid/ready response port.
- Sits between requester logic and the multiplier; drives its en, data and clear inputs.

Parameters:
- DATA_WIDTH, 4, bits per operand (matches sc_serial_mul).
- NUM_INPUTS, 2, operands per operation.
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT_CYCLES, 1024, maximum RUN cycles before abort (>=2).
- ID_W, $clog2(NUM_REQ), derived, requester-id width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_data  in  NUM_REQ*NUM_INPUTS*DATA_WIDTH  operands; requester r occupies slice r, operand i at bits [(r*NUM_INPUTS+i)*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[r]&req_ready[r].
- mul_clr  out  1  active-high one-cycle clear to multiplier.
- mul_en  out  1  multiplier enable.
- mul_data_in  out  NUM_INPUTS*DATA_WIDTH  latched operands, operand i at [i*DATA_WIDTH +: DATA_WIDTH].
- mul_data_out  in  NUM_INPUTS*DATA_WIDTH  multiplier result.
- mul_done  in  1  multiplier completion.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accept.
- resp_id  out  ID_W  requester that owns the response.
- resp_data  out  NUM_INPUTS*DATA_WIDTH  result.
- resp_err  out  1  1 = timeout abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, CLEAR, RUN, RESP.
- Reset (rst=0, asynchronous, any state including mid-RUN):
  - state=IDLE, rr pointer=0, cycle counter=0.
  - All outputs 0, including mul_data_in, resp_*, req_ready, mul_en, mul_clr.
- IDLE:
  - req_ready is combinational: one-hot for the first asserted req_valid searching upward from the pointer, with wrap.
  - On transfer: latch that slice into mul_data_in, latch the id, set pointer=(id+1) mod NUM_REQ, go to CLEAR.
  - With no request, stay in IDLE with req_ready=0.
- CLEAR: mul_clr=1 and mul_en=0 for exactly one cycle; counter cleared; go to RUN.
- RUN:
  - mul_en=1; counter increments each cycle.
  - If mul_done=1: register mul_data_out into resp_data, resp_err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: resp_data=0, resp_err=1, go to RESP.
  - mul_done and timeout in the same cycle: done wins.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err held stable until resp_ready=1.
  - Handshake cycle: go to IDLE; resp_valid falls next cycle.
  - mul_en=0; req_ready=0 throughout.
- mul_done outside RUN is ignored.
- mul_data_in holds its value from grant until the next grant.
- Latency: grant in cycle T; mul_clr in T+1; mul_en high from T+2.
  - If mul_done arrives in cycle D, resp_valid=1 in D+1.
  - Minimum grant-to-grant time is 4 cycles (done on first RUN cycle, resp_ready held high).
- Requests are not queued; a requester holds req_valid until granted.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.

Test Plan:
- Req 0 sends {op1=0x6, op0=0xA}; multiplier model asserts done after 16 RUN cycles with 0x3C -> mul_clr at T+1, mul_en T+2..T+17, resp_valid at T+18 with resp_id=0, resp_data=0x3C, resp_err=0.
- req_valid=4'b1111 held continuously, resp_ready=1 -> grant order 0,1,2,3,0; resp_id sequence matches; each req_ready pulse lasts 1 cycle.
- resp_ready held low 5 cycles in RESP with req 1 pending -> resp_valid/resp_data/resp_id stable; req_ready=0; grant to 1 only after the handshake.
- TIMEOUT_CYCLES=32, model never asserts done -> resp_valid after 32 RUN cycles with resp_err=1, resp_data=0; mul_en drops the cycle after.
- rst pulled low at RUN cycle 5 -> all outputs 0 immediately (asynchronous); after release, req_valid=4'b0101 -> requester 0 granted first (pointer reset).
- mul_done asserted on RUN cycle TIMEOUT_CYCLES-1 with 0x21 -> resp_err=0, resp_data=0x21.
